// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin / manual-select stream multiplexer.
// Holds the mode encodings and the index-width helper used by every file.
package stream_mux_rr_pkg;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_SEL = 1'b1;

    // Width of a channel index; never narrower than one bit.
    function automatic int selWidth(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational grant logic: rotating-priority scan from ptr, or a direct
// channel pick from sel when manual mode is active.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = selWidth(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    int w_idx;

    // Descending offset scan so the channel closest to ptr is written last and wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        w_idx       = 0;
        if (mode == MODE_SEL) begin
            for (int i = 0; i < NCH; i++) begin
                if (int'(sel) == i) begin
                    grant       = sel;
                    grant_valid = req[i];
                end
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                w_idx = int'(ptr) + k;
                if (w_idx >= NCH) begin
                    w_idx = w_idx - NCH;
                end
                if (req[w_idx]) begin
                    grant       = SELW'(w_idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with a single registered output stage.
// Round-robin pointer and output register live here; grant logic is in rr_arbiter.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int SELW  = selWidth(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_outData;
    logic [SELW-1:0]  r_outCh;
    logic             r_outValid;

    logic [SELW-1:0]  w_grant;
    logic             w_grantValid;
    logic             w_loadEn;
    logic             w_accept;
    logic [WIDTH-1:0] w_selData;
    logic [SELW-1:0]  w_nextPtr;

    rr_arbiter #(
        .NCH(NCH)
    ) u_arbiter (
        .req        (in_valid),
        .ptr        (r_ptr),
        .mode       (mode),
        .sel        (sel),
        .grant      (w_grant),
        .grant_valid(w_grantValid)
    );

    assign w_loadEn  = !r_outValid || out_ready;
    assign w_accept  = w_loadEn && w_grantValid && !rst;
    assign w_nextPtr = (int'(w_grant) == NCH - 1) ? '0 : w_grant + 1'b1;

    // Ready is one-hot on the granted channel and forced low during reset.
    always_comb begin
        in_ready  = '0;
        w_selData = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = w_accept && (int'(w_grant) == i);
            if (int'(w_grant) == i) begin
                w_selData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_outValid <= 1'b0;
        end else if (w_loadEn) begin
            if (w_grantValid) begin
                r_outData  <= w_selData;
                r_outCh    <= w_grant;
                r_outValid <= 1'b1;
                if (mode == MODE_RR) begin
                    r_ptr <= w_nextPtr;
                end
            end else begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_data  = r_outData;
    assign out_ch    = r_outCh;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized and directed bench for stream_mux_rr, run side by side on a
// 4-channel and a 3-channel instance against a queue-free behavioural model.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] inData;
    logic [3:0]  inValid;
    logic        outReady;

    logic [3:0]  readyA;
    logic [7:0]  dataA;
    logic [1:0]  chA;
    logic        validA;

    logic [2:0]  readyB;
    logic [7:0]  dataB;
    logic [1:0]  chB;
    logic        validB;

    int          checks = 0;
    int          errors = 0;

    int          mPtr[2];
    bit          mValid[2];
    logic [7:0]  mData[2];
    int          mCh[2];
    int          nch[2] = '{4, 3};

    logic [7:0]  xWord;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .NCH(4)) dutA (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .in_data  (inData),
        .in_valid (inValid),
        .in_ready (readyA),
        .out_data (dataA),
        .out_ch   (chA),
        .out_valid(validA),
        .out_ready(outReady)
    );

    stream_mux_rr #(.WIDTH(8), .NCH(3)) dutB (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .sel      (sel),
        .in_data  (inData[23:0]),
        .in_valid (inValid[2:0]),
        .in_ready (readyB),
        .out_data (dataB),
        .out_ch   (chB),
        .out_valid(validB),
        .out_ready(outReady)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Which channel the rules pick: manual index if in range, else first valid from ptr onward.
    task automatic modelGrant(input int n, input int ptr, input logic md, input int s,
                              input logic [3:0] v, output bit gv, output int g);
        gv = 1'b0;
        g  = 0;
        if (md) begin
            if (s < n && v[s]) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int off = 0; off < n; off++) begin
                if (!gv && v[(ptr + off) % n]) begin
                    gv = 1'b1;
                    g  = (ptr + off) % n;
                end
            end
        end
    endtask

    task automatic modelClear();
        for (int d = 0; d < 2; d++) begin
            mPtr[d]   = 0;
            mValid[d] = 1'b0;
            mData[d]  = 8'h00;
            mCh[d]    = 0;
        end
    endtask

    task automatic checkRegs();
        checkOutput("A.out_valid", 32'(validA), 32'(mValid[0]));
        checkOutput("A.out_data",  32'(dataA),  32'(mData[0]));
        checkOutput("A.out_ch",    32'(chA),    32'(mCh[0]));
        checkOutput("B.out_valid", 32'(validB), 32'(mValid[1]));
        checkOutput("B.out_data",  32'(dataB),  32'(mData[1]));
        checkOutput("B.out_ch",    32'(chB),    32'(mCh[1]));
    endtask

    // Drive one cycle of inputs, check ready mid-cycle, clock, then check registers.
    task automatic applyStimulus(input logic md, input logic [1:0] s, input logic [3:0] v,
                                 input logic [31:0] d, input logic r);
        bit   gv[2];
        int   g[2];
        bit   ld[2];
        logic [3:0] v2;
        mode     = md;
        sel      = s;
        inValid  = v;
        inData   = d;
        outReady = r;
        #3;
        for (int k = 0; k < 2; k++) begin
            v2 = (k == 0) ? v : (v & 4'b0111);
            modelGrant(nch[k], mPtr[k], md, int'(s), v2, gv[k], g[k]);
            ld[k] = !mValid[k] || r;
        end
        checkOutput("A.in_ready", 32'(readyA), (ld[0] && gv[0]) ? (32'd1 << g[0]) : 32'd0);
        checkOutput("B.in_ready", 32'(readyB), (ld[1] && gv[1]) ? (32'd1 << g[1]) : 32'd0);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (ld[k]) begin
                if (gv[k]) begin
                    mData[k]  = d[g[k]*8 +: 8];
                    mCh[k]    = g[k];
                    mValid[k] = 1'b1;
                    if (!md) begin
                        mPtr[k] = (g[k] + 1) % nch[k];
                    end
                end else begin
                    mValid[k] = 1'b0;
                end
            end
        end
        #1;
        checkRegs();
    endtask

    // Two reset cycles with every channel requesting; ends just after a rising edge.
    task automatic doReset();
        rst      = 1'b1;
        mode     = 1'b0;
        sel      = 2'd0;
        inValid  = 4'hF;
        outReady = 1'b1;
        inData   = $urandom;
        modelClear();
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("rst.A.out_valid", 32'(validA), 32'd0);
            checkOutput("rst.A.out_data",  32'(dataA),  32'd0);
            checkOutput("rst.A.out_ch",    32'(chA),    32'd0);
            checkOutput("rst.A.in_ready",  32'(readyA), 32'd0);
            checkOutput("rst.B.in_ready",  32'(readyB), 32'd0);
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        xWord = 8'b1xx0_0000;

        // Reset, then first word must come from channel 0.
        doReset();
        applyStimulus(1'b0, 2'd0, 4'hF, 32'hA3A2A1A0, 1'b1);
        checkOutput("first.ch",   32'(chA),   32'd0);
        checkOutput("first.data", 32'(dataA), 32'hA0);

        // Round-robin fairness over all valid channels.
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 2'd0, 4'hF, 32'hA3A2A1A0, 1'b1);
            checkOutput("rr.ch",   32'(chA),   32'(k % 4));
            checkOutput("rr.data", 32'(dataA), 32'(8'hA0 + k % 4));
        end

        // Pointer skips idle channels and wraps.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 2'd0, 4'b1010, 32'hA3A2A1A0, 1'b1);
            checkOutput("skip.ch", 32'(chA), (k == 1) ? 32'd3 : 32'd1);
        end

        // Manual select, including an idle selected channel and an out-of-range index.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 2'd2, 4'hF, 32'h115C2233, 1'b1);
            checkOutput("sel.ch",   32'(chA),   32'd2);
            checkOutput("sel.data", 32'(dataA), 32'h5C);
        end
        applyStimulus(1'b1, 2'd2, 4'b1011, 32'h115C2233, 1'b1);
        checkOutput("sel.idle.valid", 32'(validA), 32'd0);
        applyStimulus(1'b1, 2'd2, 4'hF, 32'h115C2233, 1'b1);
        applyStimulus(1'b1, 2'd3, 4'hF, 32'h115C2233, 1'b1);
        checkOutput("sel.range.B.valid", 32'(validB), 32'd0);

        // Backpressure holds everything; release loads without a bubble.
        doReset();
        applyStimulus(1'b0, 2'd0, 4'hF, 32'hA3A2A1A0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 2'd0, 4'hF, 32'hB3B2B1B0, 1'b0);
            checkOutput("bp.ch",   32'(chA),   32'd0);
            checkOutput("bp.data", 32'(dataA), 32'hA0);
        end
        applyStimulus(1'b0, 2'd0, 4'hF, 32'hB3B2B1B0, 1'b1);
        checkOutput("bp.release.valid", 32'(validA), 32'd1);
        checkOutput("bp.release.ch",    32'(chA),    32'd1);

        // Unknown bits pass straight through, then reset lands mid-cycle.
        applyStimulus(1'b1, 2'd3, 4'b1000, {xWord, 24'h123456}, 1'b1);
        checkOutput("x.data", 32'(dataA), 32'(xWord));
        applyStimulus(1'b0, 2'd0, 4'hF, 32'hA3A2A1A0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst.valid", 32'(validA), 32'd0);
        checkOutput("midrst.data",  32'(dataA),  32'd0);
        checkOutput("midrst.ready", 32'(readyA), 32'd0);
        #1;
        rst = 1'b0;
        modelClear();
        applyStimulus(1'b0, 2'd0, 4'hF, 32'hA3A2A1A0, 1'b1);
        checkOutput("midrst.next.ch", 32'(chA), 32'd0);

        // Randomized traffic, leaning toward round-robin mode.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, WIDTH-bit stream multiplexer. It is the clocked successor of the 4:1 combinational mux.
- Each input channel has a valid/ready handshake.
- Two selection modes: round-robin arbitration, or a manual channel select.
- A single registered output stage carries the selected word and its channel index downstream.

Parameters:
WIDTH, 8, data bits per channel
NCH, 4, number of input channels (2..16, need not be a power of two)
SELW, derived = max(1, clog2(NCH)), width of channel index (localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
mode  input  1  0 = round-robin, 1 = manual select via sel
sel  input  SELW  channel index used when mode = 1
in_data  input  NCH*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready (combinational)
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  registered index of the channel that supplied out_data
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready

Behaviour:
- Reset (async, rst = 1): out_valid = 0, out_data = 0, out_ch = 0, rr pointer ptr = 0. in_ready is all 0 while rst is high.
- load_en = !out_valid || out_ready. This is a single pipeline register: full throughput, 1 word per cycle.
- Grant (combinational, from current inputs):
  - mode = 1: grant_valid = (sel < NCH) && in_valid[sel]; grant = sel. If sel >= NCH, no grant is made and all in_ready stay 0.
  - mode = 0: scan channels ptr, ptr+1, ..., wrapping mod NCH. The first one with in_valid set wins. grant_valid = |in_valid.
- in_ready[i] = load_en && grant_valid && (grant == i). At most one in_ready is high per cycle.
- Transfer on input i: in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= in_data[i]
  - out_ch <= i
  - out_valid <= 1
  - in mode 0 only, ptr <= (i + 1) mod NCH, wrapping from NCH-1 to 0.
- load_en high but no grant: out_valid <= 0 at the next edge; out_data and out_ch hold.
- load_en low (out_valid && !out_ready): out_data, out_ch and out_valid hold; ptr holds.
- Latency: input accepted at edge k appears on out_* after edge k (1 cycle).
- Data is passed bit-exact, including X/Z bits. No masking.
- mode and sel changes take effect in the same cycle. ptr is not modified in mode 1 and resumes from its held value when mode returns to 0.
- Simultaneous events: a word may be accepted in the same cycle the current output word is consumed (out_ready = 1).
- Reset asserted mid-transfer discards the output word and returns ptr to 0. No partial state survives.

Decomposition:
- Shared include stream_mux_defs.vh: MODE_RR = 1'b0, MODE_SEL = 1'b1, clog2 function/macro for SELW.
- One sub-module, rr_arbiter. It is parameterised by NCH and takes req[NCH], ptr, and mode/sel. It outputs grant[SELW] and grant_valid, and is purely combinational.
- ptr and the output register live in stream_mux_rr.

Test Plan:
1. Reset: rst = 1 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0000 throughout. Release rst -> first word is from ch0 after 1 cycle.
2. Round-robin fairness: NCH = 4, mode = 0, all in_valid = 1, out_ready = 1, in_data[i] = 8'hA0+i -> out_ch = 0,1,2,3,0,1 on consecutive cycles, out_data = A0,A1,A2,A3,A0,A1.
3. Pointer skip and wrap: in_valid = 1010, ptr = 0 -> grants ch1, then ch3, then ch1. Channels 0 and 2 never get in_ready.
4. Manual select: mode = 1, sel = 2, in_valid = 1111, in_data[2] = 8'h5C -> out_ch = 2, out_data = 5C every cycle. sel = 2 with in_valid[2] = 0 -> out_valid = 0 next cycle. NCH = 3 with sel = 3 -> no in_ready, out_valid drops.
5. Backpressure: out_valid = 1, out_ready = 0 for 3 cycles -> out_data, out_ch and ptr hold, in_ready = 0. Raising out_ready with in_valid = 1 -> new word loads on the same edge, no bubble.
6. X passthrough and reset mid-stream: in_data[3] = 8'b1xx0_0000 on ch3 -> out_data shows 1xx00000. Pulse rst between clock edges while out_valid = 1 -> outputs clear immediately, and the next grant starts from ch0.
